// File: rtl/cycle_load_ctrl_pkg.sv
// Shared types and constants for the cycle-register loader.
package cycle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMPTY = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned MIN_PERIOD   = 3;
  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_PERIOD_W = 16;

endpackage

// File: rtl/cycle_load_ctrl_if.sv
// Run control, pattern handshake and bank drive signals of the loader.
interface cycle_load_ctrl_if #(
  parameter int unsigned WIDTH    = cycle_pkg::DEF_WIDTH,
  parameter int unsigned PERIOD_W = cycle_pkg::DEF_PERIOD_W
);

  logic                ENABLE;
  logic [PERIOD_W-1:0] PERIOD;
  logic [WIDTH-1:0]    DATA_IN;
  logic                DATA_VALID;
  logic                DATA_READY;
  logic [WIDTH-1:0]    D;
  logic                LOAD;
  logic                TRANSFER;
  logic                CYCLE_START;
  logic                UNDERRUN;
  logic                UNDERRUN_STICKY;

  modport master (
    output ENABLE, PERIOD, DATA_IN, DATA_VALID,
    input  DATA_READY, D, LOAD, TRANSFER, CYCLE_START, UNDERRUN, UNDERRUN_STICKY
  );

  modport slave (
    input  ENABLE, PERIOD, DATA_IN, DATA_VALID,
    output DATA_READY, D, LOAD, TRANSFER, CYCLE_START, UNDERRUN, UNDERRUN_STICKY
  );

endinterface

// File: rtl/cycle_load_ctrl_counter.sv
// Test-cycle period counter: cnt/per registers, terminal count and load window.
module cycle_period_counter
  import cycle_pkg::*;
#(
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                running,
  input  logic [PERIOD_W-1:0] period,
  output logic                tc,
  output logic                first,
  output logic                window
);

  localparam logic [PERIOD_W-1:0] MIN_PER = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] TWO     = PERIOD_W'(2);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] per_clamped;

  assign per_clamped = (period < MIN_PER) ? MIN_PER : period;

  // per_q >= 3 always, so per_q-2 never wraps
  assign tc     = running && (cnt_q == per_q - ONE);
  assign first  = running && (cnt_q == '0);
  assign window = cnt_q < (per_q - TWO);

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (!running || tc) begin
      cnt_d = '0;
      per_d = per_clamped;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      per_q <= MIN_PER;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/cycle_load_ctrl.sv
// Feeds one pattern word per test cycle into a double-buffered register bank,
// pulsing TRANSFER at each cycle boundary and flagging underruns.
module cycle_load_ctrl
  import cycle_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic               CLK,
  input  logic               RST,
  cycle_load_ctrl_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             load_q, load_d;
  logic             sticky_q, sticky_d;

  logic running, tc, first, window;
  logic ready, accept, boundary, transfer, underrun;

  assign running = (state_q != ST_IDLE);

  cycle_period_counter #(
    .PERIOD_W (PERIOD_W)
  ) u_counter (
    .clk     (CLK),
    .rst     (RST),
    .enable  (bus.ENABLE),
    .running (running),
    .period  (bus.PERIOD),
    .tc      (tc),
    .first   (first),
    .window  (window)
  );

  always_comb begin
    state_d  = state_q;
    ready    = (state_q == ST_EMPTY) && window;
    accept   = bus.DATA_VALID && ready;
    // a boundary coinciding with ENABLE falling is abandoned, not transferred
    boundary = tc && bus.ENABLE;
    transfer = boundary && (state_q == ST_FULL);
    underrun = boundary && (state_q == ST_EMPTY);
    load_d   = accept && bus.ENABLE;
    d_d      = load_d ? bus.DATA_IN : d_q;
    sticky_d = bus.ENABLE ? (sticky_q || underrun) : 1'b0;

    unique case (state_q)
      ST_IDLE:  if (bus.ENABLE) state_d = ST_EMPTY;
      ST_EMPTY: begin
        if (!bus.ENABLE)  state_d = ST_IDLE;
        else if (accept)  state_d = ST_FULL;
      end
      ST_FULL: begin
        if (!bus.ENABLE)  state_d = ST_IDLE;
        else if (tc)      state_d = ST_EMPTY;
      end
      default:            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      d_q      <= '0;
      load_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      load_q   <= load_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.DATA_READY      = ready;
  assign bus.D               = d_q;
  assign bus.LOAD            = load_q;
  assign bus.TRANSFER        = transfer;
  assign bus.CYCLE_START     = first;
  assign bus.UNDERRUN        = underrun;
  assign bus.UNDERRUN_STICKY = sticky_q || underrun;

endmodule

// File: tb/tb_cycle_load_ctrl.sv
// Scoreboard bench for cycle_load_ctrl: directed scenarios plus random traffic
// checked against a test-cycle level reference model.
module tb_cycle_load_ctrl;
  import cycle_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cycle_load_ctrl_if #(.WIDTH(W), .PERIOD_W(PW)) bus ();

  cycle_load_ctrl #(.WIDTH(W), .PERIOD_W(PW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  typedef struct {
    int         cyc;
    logic [7:0] word;
  } ev_t;

  ev_t load_exp[$];
  ev_t xfer_exp[$];
  int  unr_exp[$];

  // Reference model: position within the current test cycle and its length.
  bit         m_run    = 1'b0;
  bit         m_full   = 1'b0;
  bit         m_sticky = 1'b0;
  int         m_pos    = 0;
  int         m_len    = 3;
  logic [7:0] m_d      = 8'h00;

  bit         exp_ready, exp_cstart, exp_sticky;
  logic [7:0] exp_d;
  bit         last_acc;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
  endfunction

  function automatic int clampp(int p);
    return (p < 3) ? 3 : p;
  endfunction

  // Expectations for the current clock, given the inputs applied in it.
  function automatic void predict(bit r, bit en, bit v, logic [7:0] w);
    bit at_end;
    at_end     = m_run && (m_pos == m_len - 1);
    exp_ready  = m_run && !m_full && (m_pos < m_len - 2);
    exp_cstart = m_run && (m_pos == 0);
    exp_d      = m_d;
    exp_sticky = m_sticky || (at_end && en && !m_full);
    last_acc   = exp_ready && v && en && !r;
    if (at_end && en && m_full)  xfer_exp.push_back('{cyc, m_d});
    if (at_end && en && !m_full) unr_exp.push_back(cyc);
    if (last_acc)                load_exp.push_back('{cyc + 1, w});
  endfunction

  function automatic void model_edge(bit r, bit en, int per, bit v, logic [7:0] w);
    if (r) begin
      m_run = 0; m_pos = 0; m_len = 3; m_full = 0; m_sticky = 0; m_d = 8'h00;
    end else if (!en) begin
      m_run = 0; m_pos = 0; m_full = 0; m_sticky = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0; m_len = clampp(per); m_full = 0;
    end else begin
      if (!m_full && (m_pos < m_len - 2) && v) begin
        m_full = 1;
        m_d    = w;
      end
      if (m_pos == m_len - 1) begin
        if (!m_full) m_sticky = 1;
        m_pos  = 0;
        m_len  = clampp(per);
        m_full = 0;
      end else begin
        m_pos++;
      end
    end
  endfunction

  task automatic step(bit r, bit en, int per, bit v, logic [7:0] w);
    logic [31:0] pv;
    pv             = per;
    rst            = r;
    bus.ENABLE     = en;
    bus.PERIOD     = pv[PW-1:0];
    bus.DATA_VALID = v;
    bus.DATA_IN    = w;
    predict(r, en, v, w);
    @(posedge clk);
    #1;
    cyc++;
    model_edge(r, en, per, v, w);
  endtask

  task automatic wait_pos(int p, int per);
    int n;
    n = 0;
    while (!(m_run && m_pos == p && m_len == clampp(per)) && n < 200) begin
      step(0, 1, per, 0, 8'h00);
      n++;
    end
    if (n >= 200) check("wait_pos_timeout", 0, 1);
  endtask

  task automatic offer(int per, logic [7:0] w);
    int n;
    n = 0;
    do begin
      step(0, 1, per, 1, w);
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) check("offer_timeout", 0, 1);
  endtask

  // Monitor: per-clock outputs plus queued LOAD/TRANSFER/UNDERRUN events.
  always @(negedge clk) begin
    if (armed) begin
      check("data_ready",  int'(bus.DATA_READY),      int'(exp_ready));
      check("cycle_start", int'(bus.CYCLE_START),     int'(exp_cstart));
      check("sticky",      int'(bus.UNDERRUN_STICKY), int'(exp_sticky));
      check("d_value",     int'(bus.D),               int'(exp_d));
      check("load_xfer_exclusive", int'(bus.LOAD && bus.TRANSFER), 0);
      assert (!(bus.LOAD && bus.TRANSFER));

      if (bus.LOAD) begin
        if (load_exp.size() == 0) check("load_unexpected", 1, 0);
        else begin
          ev_t e;
          e = load_exp.pop_front();
          check("load_cycle", cyc, e.cyc);
          check("load_d", int'(bus.D), int'(e.word));
        end
      end else if (load_exp.size() > 0 && load_exp[0].cyc <= cyc) begin
        void'(load_exp.pop_front());
        check("load_seen", 0, 1);
      end

      if (bus.TRANSFER) begin
        if (xfer_exp.size() == 0) check("transfer_unexpected", 1, 0);
        else begin
          ev_t e;
          e = xfer_exp.pop_front();
          check("transfer_cycle", cyc, e.cyc);
          check("transfer_d", int'(bus.D), int'(e.word));
        end
      end else if (xfer_exp.size() > 0 && xfer_exp[0].cyc <= cyc) begin
        void'(xfer_exp.pop_front());
        check("transfer_seen", 0, 1);
      end

      if (bus.UNDERRUN) begin
        if (unr_exp.size() == 0) check("underrun_unexpected", 1, 0);
        else check("underrun_cycle", cyc, unr_exp.pop_front());
      end else if (unr_exp.size() > 0 && unr_exp[0] <= cyc) begin
        void'(unr_exp.pop_front());
        check("underrun_seen", 0, 1);
      end
    end
  end

  initial begin
    // reset held 3 clocks with ENABLE and DATA_VALID high
    step(1, 1, 8, 1, 8'hFF);
    armed = 1'b1;
    step(1, 1, 8, 1, 8'hFF);
    step(1, 1, 8, 1, 8'hFF);

    // PERIOD=8, word offered at cnt=0
    wait_pos(0, 8);
    offer(8, 8'hA5);
    wait_pos(0, 8);

    // late offer at cnt=6: underrun, accepted next cycle
    wait_pos(6, 8);
    offer(8, 8'h5A);
    wait_pos(0, 8);

    // period below minimum behaves as 3
    offer(1, 8'h01);
    offer(1, 8'h02);
    offer(1, 8'h03);
    for (int i = 0; i < 1000; i++) step(0, 1, 1, 1'($urandom), 8'($urandom));

    // ENABLE dropped while FULL
    wait_pos(0, 10);
    offer(10, 8'h3C);
    wait_pos(4, 10);
    step(0, 0, 10, 0, 8'h00);
    step(0, 0, 10, 0, 8'h00);
    step(0, 1, 10, 0, 8'h00);
    step(0, 1, 10, 0, 8'h00);

    // PERIOD change mid-cycle only takes effect at the next boundary
    wait_pos(3, 8);
    for (int i = 0; i < 20; i++) step(0, 1, 5, 0, 8'h00);

    // random traffic with occasional disable, reset and period changes
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) != 0,
           int'($urandom_range(0, 12)), 1'($urandom), 8'($urandom));

    for (int i = 0; i < 3; i++) step(0, 0, 8, 0, 8'h00);
    check("pending_events", load_exp.size() + xfer_exp.size() + unr_exp.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cycle_load_ctrl.md
Name: cycle_load_ctrl

Overview:
- Upstream feeder for a bank of WIDTH double-buffered cycle registers. The bank has a LOAD-into-buffer stage and a TRANSFER-to-output stage, and LOAD has priority over TRANSFER.
- Accepts one test-cycle pattern word per handshake and drives D/LOAD into the bank's buffer stage.
- Pulses TRANSFER exactly at each programmable test-cycle boundary, so all pattern bits change together.
- Guarantees LOAD and TRANSFER are never asserted in the same clock, and flags underruns.

Parameters:
- WIDTH, 8: pattern bits per test cycle (number of downstream cycle registers).
- PERIOD_W, 16: width of the test-cycle period counter.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- ENABLE  in  1  run control; low = idle and flush.
- PERIOD  in  PERIOD_W  clocks per test cycle; values < 3 are treated as 3; sampled only when the counter reaches terminal count (TC).
- DATA_IN  in  WIDTH  next pattern word.
- DATA_VALID  in  1  DATA_IN valid.
- DATA_READY  out  1  loader can accept a word this clock.
- D  out  WIDTH  registered pattern to the bank's D inputs.
- LOAD  out  1  one-clock pulse: the bank captures D into its buffer.
- TRANSFER  out  1  one-clock pulse: the bank moves buffer to output.
- CYCLE_START  out  1  one-clock pulse on the first clock of each test cycle.
- UNDERRUN  out  1  one-clock pulse: boundary reached with no word loaded.
- UNDERRUN_STICKY  out  1  latched underrun; cleared by RST or ENABLE low.

Behaviour:
- Reset (RST=1 at an edge): all outputs 0, D=0, counter cnt=0, state IDLE, period register per=3. Reset overrides everything, including mid-cycle and mid-handshake; any pending word is dropped.
- States:
  - IDLE: ENABLE=0; cnt held at 0.
  - EMPTY: running, buffer not loaded this cycle.
  - FULL: word loaded, waiting for the boundary.
- IDLE -> EMPTY when ENABLE=1.
  - The first active clock has cnt=0 and CYCLE_START=1.
  - per is loaded from max(PERIOD,3) on entry.
- Counter: cnt increments every clock while running; TC is cnt==per-1. At TC, cnt wraps to 0 on the next clock and per is reloaded from PERIOD.
- CYCLE_START=1 on every clock where cnt==0 while running.
- DATA_READY = (state==EMPTY) && (cnt < per-2). It is combinational from state and cnt only, never from DATA_VALID.
- Accept: when DATA_VALID && DATA_READY at clock N:
  - At N+1, D=DATA_IN and LOAD=1 for one clock.
  - State becomes FULL at N+1.
  - The latest accept is at cnt=per-3, so LOAD appears no later than cnt=per-2. LOAD can therefore never coincide with TRANSFER at TC.
- D holds its value until the next accept; it does not change on TRANSFER.
- Boundary, state FULL at TC: TRANSFER=1 at that clock; the next clock has state EMPTY and cnt=0.
- Boundary, state EMPTY at TC:
  - TRANSFER=0, so the bank's outputs hold the previous pattern.
  - UNDERRUN=1 for that clock and UNDERRUN_STICKY is set.
- At most one word is accepted per test cycle. DATA_READY stays low in FULL even if cnt is small.
- ENABLE falling while running: the next clock goes to IDLE.
  - cnt is cleared to 0 and DATA_READY drops.
  - A FULL word is discarded without TRANSFER.
  - UNDERRUN_STICKY is cleared.
  - A handshake completing in the clock where ENABLE falls is still dropped; LOAD is suppressed.
- A PERIOD change mid-cycle has no effect until the next TC.
- Widths: cnt and per are PERIOD_W bits; the comparison per-2 uses per>=3, so there is no underflow.

Decomposition:
- Shared package cycle_pkg holds:
  - state encoding (IDLE, EMPTY, FULL);
  - MIN_PERIOD=3 constant;
  - default WIDTH and PERIOD_W values for the tester top.
- One natural sub-module: cycle_period_counter. It contains cnt, per and the reload logic, and outputs tc and first.
- The handshake/state FSM and the D register stay in cycle_load_ctrl.

Test Plan:
- RST high 3 clocks with ENABLE=1 and DATA_VALID=1: all outputs 0 and D=0.
- PERIOD=8, ENABLE=1, word 0xA5 offered at cnt=0:
  - LOAD at cnt=1 with D=0xA5;
  - TRANSFER at cnt=7;
  - CYCLE_START on the next clock;
  - DATA_READY high again at cnt=0.
- PERIOD=8, DATA_VALID first raised at cnt=6: DATA_READY stays 0, so there is no accept.
  - TC at cnt=7 gives UNDERRUN=1 and UNDERRUN_STICKY=1.
  - The word is accepted at cnt=0 of the next cycle.
- PERIOD=1 programmed: behaves as period 3.
  - TRANSFER every 3 clocks with back-to-back words 0x01, 0x02, 0x03.
  - LOAD and TRANSFER are never high together; checked by an assertion across 1000 random-VALID cycles.
- Word 0x3C loaded (FULL), ENABLE dropped at cnt=4 of PERIOD=10: no TRANSFER.
  - IDLE next clock with DATA_READY=0 and UNDERRUN_STICKY=0.
  - Re-enable restarts at cnt=0 with CYCLE_START=1.
- PERIOD changed from 8 to 5 at cnt=3: the current cycle still TCs at cnt=7; the next cycle TCs at cnt=4.
